// File: rtl/gamepad_poller_pkg.sv
// Shared definitions for the serial gamepad poller: FSM encoding,
// default geometry, SNES button indices and a counter-width helper.
package gamepad_poller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_CLK_HI = 3'd4,
        ST_DONE   = 3'd5
    } poll_state_t;

    localparam int DEFAULT_BITS = 12;

    // Button positions inside one port's slice (SNES shift order)
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Width of a counter that must index 0..n-1 (never narrower than 1 bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gamepad_poller_pad_shift_capture.sv
// Per-port shadow register: each sample strobe stores the inverted pad
// data line at the bit position given by the poller's bit counter.
module pad_shift_capture
    import gamepad_poller_pkg::*;
#(
    parameter int NBITS = 13,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic             data_n,
    input  logic [IDXW-1:0]  bit_idx,
    output logic [NBITS-1:0] snapshot
);

    logic [NBITS-1:0] r_shadow;

    // Capture one sample (pressed = 1) into the addressed shadow bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (sample_en) begin
            r_shadow[bit_idx] <= ~data_n;
        end else begin
            r_shadow <= r_shadow;
        end
    end

    assign snapshot = r_shadow;

endmodule

// File: rtl/gamepad_poller.sv
// Multi-port SNES-style pad poller: drives a shared latch/clock pair,
// shifts all pad data lines in parallel and publishes an atomic snapshot.
module gamepad_poller
    import gamepad_poller_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int BITS          = DEFAULT_BITS,
    parameter int HALF_PERIOD   = 6,
    parameter int ENABLE_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  poll_start,
    output logic                  pad_latch,
    output logic                  pad_clk,
    input  logic [PORTS-1:0]      pad_data_n,
    output logic [PORTS*BITS-1:0] buttons,
    output logic [PORTS-1:0]      connected,
    output logic                  valid,
    output logic                  busy
);

    localparam int NBITS = BITS + ((ENABLE_DETECT != 0) ? 1 : 0);
    localparam int IDXW  = cnt_width(NBITS);
    localparam int DIVW  = cnt_width(2 * HALF_PERIOD);

    localparam logic [DIVW-1:0] DIV_T_LAST  = DIVW'(HALF_PERIOD - 1);
    localparam logic [DIVW-1:0] DIV_2T_LAST = DIVW'(2 * HALF_PERIOD - 1);
    localparam logic [IDXW-1:0] IDX_LAST    = IDXW'(NBITS - 1);

    poll_state_t             r_state;
    poll_state_t             w_next;
    logic [DIVW-1:0]         r_div;
    logic [IDXW-1:0]         r_bit_idx;
    logic                    r_pad_latch;
    logic                    r_pad_clk;
    logic                    r_valid;
    logic                    r_busy;
    logic [PORTS*BITS-1:0]   r_buttons;
    logic [PORTS-1:0]        r_connected;

    logic                    w_div_last;
    logic                    w_sample_en;
    logic [PORTS*NBITS-1:0]  w_snap;
    logic [PORTS-1:0]        w_conn;
    logic [PORTS*BITS-1:0]   w_btn;

    pad_shift_capture #(
        .NBITS (NBITS),
        .IDXW  (IDXW)
    ) u_cap [PORTS-1:0] (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (w_sample_en),
        .data_n    (pad_data_n),
        .bit_idx   (r_bit_idx),
        .snapshot  (w_snap)
    );

    // Final cycle of the current phase: latch lasts 2T, every other phase T
    always_comb begin
        if (r_state == ST_LATCH) begin
            w_div_last = (r_div == DIV_2T_LAST);
        end else begin
            w_div_last = (r_div == DIV_T_LAST);
        end
    end

    // Next-state and sample-strobe decode
    always_comb begin
        w_next      = r_state;
        w_sample_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (poll_start) w_next = ST_LATCH;
                else            w_next = ST_IDLE;
            end
            ST_LATCH: begin
                if (w_div_last) w_next = ST_SETTLE;
                else            w_next = ST_LATCH;
            end
            ST_SETTLE: begin
                if (w_div_last) begin
                    w_sample_en = 1'b1;
                    if (IDX_LAST == '0) w_next = ST_DONE;
                    else                w_next = ST_CLK_LO;
                end else begin
                    w_next = ST_SETTLE;
                end
            end
            ST_CLK_LO: begin
                if (w_div_last) w_next = ST_CLK_HI;
                else            w_next = ST_CLK_LO;
            end
            ST_CLK_HI: begin
                if (w_div_last) begin
                    w_sample_en = 1'b1;
                    if (r_bit_idx == IDX_LAST) w_next = ST_DONE;
                    else                       w_next = ST_CLK_LO;
                end else begin
                    w_next = ST_CLK_HI;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Absent pads (presence bit not pulled low) report no buttons
    always_comb begin
        w_conn = '0;
        w_btn  = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (ENABLE_DETECT != 0) w_conn[p] = w_snap[p*NBITS + NBITS - 1];
            else                    w_conn[p] = 1'b1;
            if (w_conn[p]) w_btn[p*BITS +: BITS] = w_snap[p*NBITS +: BITS];
            else           w_btn[p*BITS +: BITS] = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Half-period divider, restarted at every phase boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (r_state == ST_IDLE || r_state == ST_DONE || w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIVW'(1);
        end
    end

    // Sample counter: index of the bit taken by the next sample strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx <= '0;
        end else if (r_state == ST_IDLE) begin
            r_bit_idx <= '0;
        end else if (w_sample_en) begin
            r_bit_idx <= r_bit_idx + IDXW'(1);
        end else begin
            r_bit_idx <= r_bit_idx;
        end
    end

    // Pad pins registered from next state so they track the FSM phase exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
        end else begin
            r_pad_latch <= (w_next == ST_LATCH);
            r_pad_clk   <= (w_next != ST_CLK_LO);
        end
    end

    // Status flags and the atomic snapshot, published by the DONE state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_buttons   <= '0;
            r_connected <= '0;
        end else begin
            r_valid <= (r_state == ST_DONE);
            r_busy  <= (r_state != ST_IDLE);
            if (r_state == ST_DONE) begin
                r_buttons   <= w_btn;
                r_connected <= w_conn;
            end else begin
                r_buttons   <= r_buttons;
                r_connected <= r_connected;
            end
        end
    end

    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign buttons   = r_buttons;
    assign connected = r_connected;

endmodule
